// File: rtl/uart_temp_pkg.sv
// uart_temp_pkg: shared ASCII constants, oversample ratio and FSM state types
// for the UART temperature receiver.
package uart_temp_pkg;
    localparam int OVS = 16;
    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] ASCII_DOT = 8'h2E;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} byte_state_t;
    typedef enum logic [1:0] {P_INT, P_FRAC, P_DONE_FRAC, P_DISCARD} parse_state_t;
endpackage

// File: rtl/uart_temp_rx_if.sv
// uart_temp_rx_if: serial input and temperature report outputs of uart_temp_rx.
interface uart_temp_rx_if;
    logic        rxd;
    logic [31:0] temp_x10;
    logic        temp_valid;
    logic        frame_err;
    logic        overflow_err;
    modport master (input rxd, output temp_x10, temp_valid, frame_err, overflow_err);
    modport slave (output rxd, input temp_x10, temp_valid, frame_err, overflow_err);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x oversampling UART byte receiver (8N1, or 8E1 when
// UART_RX_PARITY_EN is defined).
module uart_rx_byte
    import uart_temp_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115200
) (
    input  logic       osc,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err
);
    localparam int DIV = CLK_HZ / (BAUD * OVS);
    localparam int DW = $clog2(DIV + 1);
    logic s1, s2, s3, tick, mid, fall, perr, strobe_n, ferr_n;
    logic [DW-1:0] div, div_n;
    logic [3:0] ph, ph_n;
    logic [2:0] bcnt, bcnt_n;
    logic [7:0] sh, sh_n;
    byte_state_t state, state_n;
    assign tick = div == DW'(DIV - 1);
    assign mid = tick && ph == 4'd15;
    assign fall = s3 & ~s2;
    assign byte_data = sh;
`ifdef UART_RX_PARITY_EN
    logic par, par_n;
    assign perr = par;
    always_ff @(posedge osc or posedge reset)
        if (reset) par <= 1'b0;
        else par <= par_n;
`else
    assign perr = 1'b0;
`endif
    always_ff @(posedge osc or posedge reset)
        if (reset) begin
            {s1, s2, s3} <= 3'b111;
            state <= B_IDLE;
            div <= '0;
            ph <= '0;
            bcnt <= '0;
            sh <= '0;
            byte_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            {s1, s2, s3} <= {rxd, s1, s2};
            state <= state_n;
            div <= div_n;
            ph <= ph_n;
            bcnt <= bcnt_n;
            sh <= sh_n;
            byte_strobe <= strobe_n;
            frame_err <= ferr_n;
        end
    always_comb begin
        state_n = state;
        div_n = tick ? '0 : div + 1'b1;
        ph_n = tick ? ph + 4'd1 : ph;
        bcnt_n = bcnt;
        sh_n = sh;
        strobe_n = 1'b0;
        ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n = par;
`endif
        case (state)
            B_IDLE: if (fall) begin
                state_n = B_START;
                div_n = '0;
                ph_n = '0;
            end
            B_START: if (tick && ph == 4'd7) begin
                state_n = s2 ? B_IDLE : B_DATA;
                ph_n = '0;
                bcnt_n = '0;
            end
            B_DATA: if (mid) begin
                sh_n = {s2, sh[7:1]};
                bcnt_n = bcnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                state_n = bcnt == 3'd7 ? B_PARITY : B_DATA;
`else
                state_n = bcnt == 3'd7 ? B_STOP : B_DATA;
`endif
            end
`ifdef UART_RX_PARITY_EN
            B_PARITY: if (mid) begin
                par_n = s2 ^ (^sh);
                state_n = B_STOP;
            end
`endif
            B_STOP: if (mid) begin
                state_n = B_IDLE;
                strobe_n = s2 & ~perr;
                ferr_n = ~s2 | perr;
            end
            default: state_n = B_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_temp_rx.sv
// uart_temp_rx: parses ASCII decimal temperature reports ("23.5\r") from a UART
// into a x10 value; UART_RX_PARITY_EN enables even parity on the link.
module uart_temp_rx
    import uart_temp_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = 115200,
    parameter int MAX_INT_DIGITS = 5
) (
    input logic osc,
    input logic reset,
    uart_temp_rx_if.master bus
);
    localparam int NW = $clog2(MAX_INT_DIGITS + 1);
    logic [7:0] b;
    logic stb, ferr, is_dig, is_term, valid, valid_n, ovf, ovf_n;
    logic [31:0] acc, acc_n, x10, x10_n;
    logic [3:0] frac, frac_n, d;
    logic [NW-1:0] nd, nd_n;
    parse_state_t ps, ps_n;
    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_byte (
        .osc(osc), .reset(reset), .rxd(bus.rxd),
        .byte_data(b), .byte_strobe(stb), .frame_err(ferr)
    );
    assign bus.temp_x10 = x10;
    assign bus.temp_valid = valid;
    assign bus.frame_err = ferr;
    assign bus.overflow_err = ovf;
    assign is_dig = b >= ASCII_0 && b <= ASCII_9;
    assign is_term = b == ASCII_CR || b == ASCII_LF;
    assign d = b[3:0];
    always_ff @(posedge osc or posedge reset)
        if (reset) begin
            ps <= P_INT;
            acc <= '0;
            frac <= '0;
            nd <= '0;
            x10 <= '0;
            valid <= 1'b0;
            ovf <= 1'b0;
        end else begin
            ps <= ps_n;
            acc <= acc_n;
            frac <= frac_n;
            nd <= nd_n;
            x10 <= x10_n;
            valid <= valid_n;
            ovf <= ovf_n;
        end
    always_comb begin
        ps_n = ps;
        acc_n = acc;
        frac_n = frac;
        nd_n = nd;
        x10_n = x10;
        valid_n = 1'b0;
        ovf_n = 1'b0;
        if (stb) begin
            if (is_term) begin
                ps_n = P_INT;
                acc_n = '0;
                frac_n = '0;
                nd_n = '0;
                valid_n = ps != P_DISCARD && nd != '0;
                x10_n = valid_n ? (acc << 3) + (acc << 1) + {28'd0, frac} : x10;
            end else if (ps == P_INT && is_dig) begin
                ovf_n = nd == NW'(MAX_INT_DIGITS);
                ps_n = ovf_n ? P_DISCARD : P_INT;
                acc_n = ovf_n ? acc : (acc << 3) + (acc << 1) + {28'd0, d};
                nd_n = ovf_n ? nd : nd + 1'b1;
            end else if (ps == P_INT && b == ASCII_DOT) begin
                ps_n = P_FRAC;
            end else if (ps == P_FRAC && is_dig) begin
                frac_n = d;
                ps_n = P_DONE_FRAC;
            end else if (!(ps == P_DONE_FRAC && is_dig)) begin
                ps_n = P_DISCARD;
            end
        end
    end
endmodule

// File: tb/tb_uart_temp_rx.sv
// tb_uart_temp_rx: directed serial frames into uart_temp_rx with hand-computed
// expected reports, pulse counts and error flags.
module tb_uart_temp_rx;
    localparam int CLK_HZ = 7_372_800;
    localparam int BAUD = 115200;
    localparam int BIT = (CLK_HZ / (BAUD * 16)) * 16;
    logic osc = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0, n_err = 0;
    int nv = 0, nf = 0, no = 0;
    int v0, f0, o0;
    uart_temp_rx_if bus();
    uart_temp_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .MAX_INT_DIGITS(5)) dut (
        .osc(osc), .reset(reset), .bus(bus)
    );
    always #5 osc = ~osc;
    always @(negedge osc) begin
        if (bus.temp_valid) nv++;
        if (bus.frame_err) nf++;
        if (bus.overflow_err) no++;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic hold(input int n);
        repeat (n) @(negedge osc);
    endtask
    task automatic send_byte(input logic [7:0] c, input logic stop);
        bus.rxd = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = c[i];
            hold(BIT);
        end
`ifdef UART_RX_PARITY_EN
        bus.rxd = ^c;
        hold(BIT);
`endif
        bus.rxd = stop;
        hold(BIT);
        bus.rxd = 1'b1;
        hold(BIT);
    endtask
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
        hold(8);
    endtask
    task automatic snap();
        v0 = nv;
        f0 = nf;
        o0 = no;
    endtask
    initial begin
        bus.rxd = 1'b1;
        hold(5);
        chk("reset temp_x10", bus.temp_x10, 0);
        chk("reset temp_valid", {31'd0, bus.temp_valid}, 0);
        chk("reset frame_err", {31'd0, bus.frame_err}, 0);
        chk("reset overflow_err", {31'd0, bus.overflow_err}, 0);
        reset = 1'b0;
        hold(BIT * 2);
        snap();
        send_str("23.5\r");
        chk("23.5 x10", bus.temp_x10, 235);
        chk("23.5 valid", nv - v0, 1);
        chk("23.5 frame_err", nf - f0, 0);
        chk("23.5 overflow", no - o0, 0);
        snap();
        send_str("22\r\n");
        chk("22 crlf x10", bus.temp_x10, 220);
        chk("22 crlf valid", nv - v0, 1);
        snap();
        send_str("21.75\n");
        chk("21.75 x10", bus.temp_x10, 217);
        chk("21.75 valid", nv - v0, 1);
        snap();
        send_byte("4", 1'b0);
        hold(8);
        chk("bad stop frame_err", nf - f0, 1);
        chk("bad stop holds x10", bus.temp_x10, 217);
        chk("bad stop valid", nv - v0, 0);
        snap();
        send_str("0\r");
        chk("zero x10", bus.temp_x10, 0);
        chk("zero valid", nv - v0, 1);
        snap();
        send_str("123456\r");
        chk("overflow pulse", no - o0, 1);
        chk("overflow valid", nv - v0, 0);
        chk("overflow holds x10", bus.temp_x10, 0);
        snap();
        send_str("19\r");
        chk("19 x10", bus.temp_x10, 190);
        chk("19 valid", nv - v0, 1);
        snap();
        bus.rxd = 1'b0;
        hold(16);
        bus.rxd = 1'b1;
        hold(BIT * 3);
        chk("glitch valid", nv - v0, 0);
        chk("glitch frame_err", nf - f0, 0);
        chk("glitch overflow", no - o0, 0);
        bus.rxd = 1'b0;
        hold(BIT);
        bus.rxd = 1'b1;
        hold(BIT);
        bus.rxd = 1'b1;
        hold(BIT);
        bus.rxd = 1'b0;
        hold(BIT / 2);
        reset = 1'b1;
        hold(1);
        chk("midframe reset temp_x10", bus.temp_x10, 0);
        chk("midframe reset temp_valid", {31'd0, bus.temp_valid}, 0);
        chk("midframe reset frame_err", {31'd0, bus.frame_err}, 0);
        chk("midframe reset overflow_err", {31'd0, bus.overflow_err}, 0);
        bus.rxd = 1'b1;
        hold(10);
        reset = 1'b0;
        hold(BIT * 2);
        snap();
        send_str("30\r");
        chk("30 x10", bus.temp_x10, 300);
        chk("30 valid", nv - v0, 1);
        chk("30 frame_err", nf - f0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/uart_temp_rx.md
# uart_temp_rx

Receive-side partner of the thermistor board's UART transmitter. It deserialises 8N1 frames on the RXD line and parses ASCII decimal temperature reports such as "23.5\r" into a 32-bit value scaled by 10, in the same scaling the motor-control comparison uses (220 = 22.0 °C). It sits in `top` beside the thermistor subsystem and lets a second board, or a loop-back test, consume temperature reports over the serial link.

## Interface
- CLK_HZ, 50_000_000, osc frequency in Hz
- BAUD, 115200, line rate
- MAX_INT_DIGITS, 5, maximum number of integer digits accepted per report
- osc  in  1  system clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high
- rxd  in  1  serial line, idles high, asynchronous to osc
- temp_x10  out  32  last accepted report ×10; reset 0
- temp_valid  out  1  one-cycle pulse when temp_x10 updates; reset 0
- frame_err  out  1  one-cycle pulse when a bad stop bit (or bad parity) is detected; reset 0
- overflow_err  out  1  one-cycle pulse when a report exceeds MAX_INT_DIGITS; reset 0

## Operation
- rxd passes through a 2-FF synchroniser. Both flops reset to 1.
- Oversample tick: a counter wraps at DIV = CLK_HZ/(BAUD*16), using truncating integer division, and gives 16 ticks per bit.
- Byte FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE to START: on a synchronised falling edge. The tick phase counter is cleared at that point.
  - START: at tick 8, if the line is low go to DATA. Otherwise, treat it as a glitch and return to IDLE with no error.
  - DATA: sample 8 bits LSB first at mid-bit (every 16 ticks).
  - STOP: sample at mid-bit. If high, issue byte_strobe with the data. If low, pulse frame_err, drop the byte, and go to IDLE. Then wait for the line to return high before re-arming.
- Parser states: INT, FRAC, DONE_FRAC, DISCARD. The initial state is INT with the accumulator cleared and the digit count at 0.
  - INT, digit '0'–'9': acc = acc*10 + d. If the digit count would exceed MAX_INT_DIGITS, pulse overflow_err and go to DISCARD.
  - INT, '.': go to FRAC.
  - FRAC, digit: frac = d, then go to DONE_FRAC.
  - DONE_FRAC, digit: ignored, so only one fractional digit is kept with no rounding.
  - '\r' or '\n' in INT, FRAC or DONE_FRAC: if at least one integer digit has been seen, set temp_x10 = acc*10 + frac (frac = 0 if absent) and pulse temp_valid. In every case, return to INT with the accumulator, frac and digit count cleared.
  - Empty line: no pulse.
  - Any other byte in any state: go to DISCARD with no error pulse.
  - DISCARD: '\r' or '\n' returns to INT with no output.
  - CRLF pairs give exactly one report, because the second terminator is an empty line.
- temp_x10 holds its value between reports. Errors never modify it.
- Arithmetic: the accumulator is 32 bits. acc*10 is built as (acc<<3)+(acc<<1). No signed values and no minus sign are supported; '-' causes DISCARD.

## Timing
- A byte is accepted at the stop-bit mid-sample (cycle S). byte_strobe is asserted at S+1.
- The parser registers its update at S+2. When the byte is a terminator, temp_valid and the temp_x10 update occur at S+2.
- frame_err pulses at S+1. overflow_err pulses at S+2.
- Reset asserted mid-frame returns every FSM to its initial state immediately and clears all outputs. The first full frame after deassertion must decode correctly.
- A falling edge during STOP wait or DISCARD still starts a new frame; the byte FSM is independent of the parser state.

## Configuration
- UART_RX_PARITY_EN defined: a PARITY state sits between DATA and STOP and checks even parity over the 8 data bits. On a mismatch, frame_err pulses at the stop-bit mid-sample and the byte is dropped.
- Undefined: the frame is 8N1 and there is no PARITY state.

## Structure
- Package uart_temp_pkg holds:
  - the ASCII constants for '0', '9', '.', CR and LF
  - the byte FSM state enum and the parser state enum
  - the OVS = 16 constant
- Sub-module uart_rx_byte contains the synchroniser, tick divider and byte FSM, and outputs byte_data[7:0], byte_strobe and frame_err. The parser lives in uart_temp_rx.

## Test plan
- "23.5\r" at 115200 → temp_valid pulses once, temp_x10 = 235, both error flags stay 0.
- "22\r\n" → temp_x10 = 220 and exactly one temp_valid pulse.
- "21.75\n" → temp_x10 = 217, the extra fractional digit is ignored.
- Frame "4" sent with stop bit low, then "0\r" → frame_err pulses once, temp_x10 = 0 (the digits "0" give 0), and temp_valid pulses once.
- "123456\r" → overflow_err pulses on the sixth digit, no temp_valid, and temp_x10 keeps its previous value. Then "19\r" gives 190.
- A 4-tick low glitch on rxd produces no byte and no error. Reset asserted during the DATA bits of a "3" clears all outputs to 0, and the subsequent "30\r" gives 300.
